// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard/sequencing controller.
//
// Signals:
//   instr_id        ID-stage instruction word
//   memread_ex      EX-stage instruction is a load
//   rt_ex           load destination register in EX
//   branch_taken_ex branch in EX resolved taken
//   pc_we, ifid_we  PC / IF-ID write enables
//   ifid_flush      zero IF/ID on next edge
//   idex_flush      bubble into ID/EX on next edge
//   mdu_start       one-cycle MDU operand-latch strobe
//   mdu_op          00 mult, 01 multu, 10 div, 11 divu (valid with mdu_start)
//   mdu_busy        MDU sequence in flight
//   mdu_done        one-cycle HI/LO write strobe
//   stall_cnt       stall cycle counter (present only with HAZ_PERF_EN)
//
// Modports: master = pipeline side, slave = hazard_ctrl.
// Optional feature macro: HAZ_PERF_EN.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [31:0] instr_id;
    logic        memread_ex;
    logic [4:0]  rt_ex;
    logic        branch_taken_ex;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        mdu_start;
    logic [1:0]  mdu_op;
    logic        mdu_busy;
    logic        mdu_done;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    modport master (
`ifdef HAZ_PERF_EN
        input  stall_cnt,
`endif
        output instr_id, memread_ex, rt_ex, branch_taken_ex,
        input  pc_we, ifid_we, ifid_flush, idex_flush,
        input  mdu_start, mdu_op, mdu_busy, mdu_done
    );

    modport slave (
`ifdef HAZ_PERF_EN
        output stall_cnt,
`endif
        input  instr_id, memread_ex, rt_ex, branch_taken_ex,
        output pc_we, ifid_we, ifid_flush, idex_flush,
        output mdu_start, mdu_op, mdu_busy, mdu_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core. Covers the
// hazards forwarding cannot resolve: load-use stalls, taken-branch squash
// and the multiply/divide interlock. Owns the MDU busy FSM and its
// iteration counter and strobes the HI/LO unit.
//
// Ports:
//   clk  core clock
//   rst  synchronous, active-high reset
//   hz   hazard_ctrl_if.slave (ID/EX hazard inputs, enables, flushes, MDU
//        strobes; see the interface file for the signal list)
//
// Parameters:
//   MUL_CYCLES  mdu_start -> mdu_done latency for mult/multu (>=1)
//   DIV_CYCLES  mdu_start -> mdu_done latency for div/divu   (>=1)
//   CNT_W       counter width, holds max(MUL_CYCLES,DIV_CYCLES)-1
//
// Optional feature macro: HAZ_PERF_EN adds hz.stall_cnt, a saturating count
// of stalled (non-squashed) cycles.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam logic [CNT_W-1:0] MUL_LAT_M1 = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAT_M1 = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;

    // Instruction field decode
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       is_md;
    logic       is_mf;
    logic       uses_rt;
    logic       lu;
    logic       ms;
    logic       stall;
    logic       issue;
    logic [CNT_W-1:0] lat_m1;
    logic       unused_instr_bits;

    assign op = hz.instr_id[31:26];
    assign rs = hz.instr_id[25:21];
    assign rt = hz.instr_id[20:16];
    assign fn = hz.instr_id[5:0];
    // rd and shamt never matter for hazard detection.
    assign unused_instr_bits = ^hz.instr_id[15:6];

    assign is_md   = (op == 6'b000000) && (fn[5:2] == 4'b0110);
    assign is_mf   = (op == 6'b000000) && ((fn == 6'b010000) || (fn == 6'b010010));
    // Stores read rt too, but store-data forwarding from MEM covers them.
    assign uses_rt = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101);

    assign lu    = hz.memread_ex && (hz.rt_ex != 5'd0) &&
                   ((hz.rt_ex == rs) || (uses_rt && (hz.rt_ex == rt)));
    assign ms    = (state != IDLE) && (is_md || is_mf);
    assign stall = lu || ms;

    // A squashed instruction must never start the MDU.
    assign issue  = !rst && !hz.branch_taken_ex && (state == IDLE) && is_md && !lu;
    assign lat_m1 = fn[1] ? DIV_LAT_M1 : MUL_LAT_M1;

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        hz.pc_we      = 1'b1;
        hz.ifid_we    = 1'b1;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;
        hz.mdu_start  = 1'b0;
        hz.mdu_op     = 2'b00;
        // Reset forces the idle view even before the edge that clears state,
        // which also suppresses a DONE pulse coinciding with reset.
        hz.mdu_busy   = !rst && (state != IDLE);
        hz.mdu_done   = !rst && (state == DONE);
        if (!rst) begin
            if (hz.branch_taken_ex) begin
                hz.ifid_flush = 1'b1;
                hz.idex_flush = 1'b1;
            end else begin
                if (stall) begin
                    hz.pc_we      = 1'b0;
                    hz.ifid_we    = 1'b0;
                    hz.idex_flush = 1'b1;
                end
                if (issue) begin
                    hz.mdu_start = 1'b1;
                    hz.mdu_op    = fn[1:0];
                end
            end
        end
    end

    // MDU sequencer: cnt is loaded with latency-1 so DONE lands exactly
    // latency cycles after the start cycle.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt   <= lat_m1;
                        state <= (lat_m1 == '0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    // Counts only stalls that actually hold the pipe; squash cycles are excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            hz.stall_cnt <= '0;
        end else if (stall && !hz.branch_taken_ex && (hz.stall_cnt != 32'hFFFF_FFFF)) begin
            hz.stall_cnt <= hz.stall_cnt + 32'd1;
        end
    end
`endif

endmodule
